lsu_ctrl: RTL and testbench
===========================

# lsu_ctrl

Load/store control unit that sits directly upstream of the core's data TCM. It accepts byte-addressed RV32I load/store requests from the memory stage and drives the TCM's word-addressed read/write ports. It performs lane extraction with sign/zero extension for loads and read-modify-write merging for sub-word stores. Misaligned or illegal accesses are flagged without touching memory.

## Interface
- AW, 4, TCM word-address width; byte address is AW+2 bits
- DW, 32, data width; only 32 supported
- CLK  in  1  clock; all state on rising edge
- RST_N  in  1  reset, asynchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  unit idle; request accepted when req_valid && req_ready
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU loads only)
- req_addr  in  AW+2  byte address
- req_wdata  in  DW  store data, right-aligned
- resp_valid  out  1  one-cycle completion pulse; no backpressure
- resp_rdata  out  DW  extended load data; 0 for stores and errors
- resp_err  out  1  misaligned or illegal funct3; valid with resp_valid
- RADDR  out  AW  TCM read word address
- REN  out  1  TCM read enable
- RDATA  in  DW  TCM combinational read data; high-Z when REN=0
- WADDR  out  AW  TCM write word address
- WDATA  out  DW  TCM write data
- WEN  out  1  TCM write enable
- RW_type  out  3  TCM write size code; 010 during WRITE, 111 (no lanes) otherwise

## Operation
- FSM states and transitions:
  - IDLE: req_ready=1. On accept, latch we, funct3, addr, and wdata, then decode.
    - Error → RESP.
    - Load → READ.
    - SW → WRITE, with the merge register set to wdata.
    - SB/SH → READ.
  - READ: REN=1, RADDR=addr[AW+1:2]; capture RDATA at the clock edge. Load → RESP with the extended result. Sub-word store → WRITE, with the merge register holding the read word and the new lane inserted.
  - WRITE: WEN=1, WADDR=addr[AW+1:2], WDATA=merge register, RW_type=010. → RESP.
  - RESP: resp_valid=1 for exactly one cycle. → IDLE.
- Errors:
  - H/HU with addr[0]=1.
  - W with addr[1:0]≠00.
  - funct3 ∈ {011, 110, 111}.
  - Store with funct3[2]=1.
  - An error produces no REN or WEN.
- Load extraction, lane = addr[1:0]:
  - B: bits [8·lane+7 : 8·lane], sign-extended from bit 7.
  - BU: the same bits, zero-extended.
  - H: half-word at addr[1], sign-extended from bit 15.
  - HU: the same half-word, zero-extended.
  - W: the full word.
- Store merge:
  - SB replaces byte lane addr[1:0] with wdata[7:0].
  - SH replaces half-word addr[1] with wdata[15:0].
  - All other bytes keep their read value.
- RDATA is sampled only in READ. Its value in any other state is ignored.
- RADDR and WADDR hold the latched word address in all states.
- WDATA always shows the merge register.

## Timing
- Reset (async assert):
  - state=IDLE.
  - REN=0, WEN=0, RW_type=111.
  - resp_valid=0, resp_rdata=0, resp_err=0.
  - All latched registers cleared.
  - req_ready=1 once reset is released.
- Accept occurs at edge T, in IDLE.
- Latency from accept edge T to resp_valid:
  - Load: READ in cycle T+1, resp_valid in T+2.
  - SW: WRITE in T+1, resp_valid in T+2.
  - SB/SH: READ in T+1, WRITE in T+2, resp_valid in T+3.
  - Error: resp_valid in T+1.
- Only one request is in flight. The next accept occurs in the IDLE cycle after RESP; sustained throughput is one load every 3 cycles.
- req_* inputs are ignored while req_ready=0.
- Reset asserted mid-operation:
  - WEN and REN drop immediately and asynchronously.
  - A WRITE in progress does not commit.
  - No resp_valid is generated for the aborted request.

## Test plan
- Reset, then SW addr 0x04 data 0xDEADBEEF. Required response:
  - Cycle T+1: WEN=1, WADDR=1, RW_type=010, WDATA=0xDEADBEEF.
  - Cycle T+2: resp_valid=1, resp_err=0.
- Loads following the SW above. Required response: REN=1 and RADDR=1 in T+1, and resp_rdata in T+2 as follows:
  - LB 0x07 → 0xFFFFFFDE.
  - LBU 0x07 → 0x000000DE.
  - LH 0x04 → 0xFFFFBEEF.
  - LHU 0x06 → 0x0000DEAD.
  - LW 0x04 → 0xDEADBEEF.
- SB addr 0x05 data 0x11. Required response:
  - READ in T+1.
  - WRITE in T+2 with WDATA=0xDEAD11EF.
  - resp_valid in T+3.
  - A subsequent LW 0x04 returns 0xDEAD11EF.
  - Also SH addr 0x06 data 0x1234 results in a word of 0x123411EF.
- Misaligned and illegal requests: LW 0x02, SH 0x03, SB with funct3=100. Required response for each:
  - resp_err=1 and resp_rdata=0 in T+1.
  - REN and WEN stay 0 throughout.
  - Memory contents unchanged.
- Hold req_valid=1 continuously with back-to-back loads. Required response:
  - req_ready=0 in T+1 and T+2.
  - The second request is accepted in the IDLE cycle T+3.
  - No request is dropped or duplicated.
- Assert RST_N=0 mid-cycle during the WRITE state of SW 0x08 data 0xCAFEF00D. Required response:
  - WEN falls before the next edge.
  - A later LW 0x08 returns the old word.
  - Outputs equal their reset values.

Source files
------------

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: RV32I load/store control in front of a word-addressed data TCM, with load extension and sub-word store read-modify-write
module lsu_ctrl #(
  parameter int AW = 4,
  parameter int DW = 32
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [2:0]    req_funct3,
  input  logic [AW+1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          resp_valid,
  output logic [DW-1:0] resp_rdata,
  output logic          resp_err,
  output logic [AW-1:0] RADDR,
  output logic          REN,
  input  logic [DW-1:0] RDATA,
  output logic [AW-1:0] WADDR,
  output logic [DW-1:0] WDATA,
  output logic          WEN,
  output logic [2:0]    RW_type
);
  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;
  state_t state_q, state_d;
  logic we_q, we_d, err_q, err_d, dec_err;
  logic [2:0] f3_q, f3_d;
  logic [AW+1:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d, lane_h;
  logic [7:0] lane_b;
  logic [DW-1:0] merge_q, merge_d, rdata_q, rdata_d, ext, merged;
  assign RADDR = addr_q[AW+1:2];
  assign WADDR = addr_q[AW+1:2];
  assign WDATA = merge_q;
  assign resp_rdata = rdata_q;
  assign resp_err = err_q;
  always_comb begin
    dec_err = req_funct3 == 3'b011 || req_funct3[2:1] == 2'b11 || (req_we && req_funct3[2]) ||
              (req_funct3[1:0] == 2'b01 && req_addr[0]) || (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
    lane_b = RDATA[{addr_q[1:0], 3'b000} +: 8];
    lane_h = addr_q[1] ? RDATA[31:16] : RDATA[15:0];
    ext = f3_q[1] ? RDATA : f3_q[0] ? {{16{~f3_q[2] & lane_h[15]}}, lane_h} : {{24{~f3_q[2] & lane_b[7]}}, lane_b};
    merged = RDATA;
    if (f3_q[0]) merged[{addr_q[1], 4'b0000} +: 16] = wdata_q;
    else merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
  end
  always_comb begin
    state_d = state_q;
    we_d = we_q;
    f3_d = f3_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    merge_d = merge_q;
    rdata_d = rdata_q;
    err_d = err_q;
    req_ready = state_q == IDLE;
    REN = 1'b0;
    WEN = 1'b0;
    RW_type = 3'b111;
    resp_valid = 1'b0;
    case (state_q)
      IDLE: if (req_valid) begin
        we_d = req_we;
        f3_d = req_funct3;
        addr_d = req_addr;
        wdata_d = req_wdata[15:0];
        rdata_d = '0;
        err_d = dec_err;
        merge_d = (req_we && !dec_err && req_funct3 == 3'b010) ? req_wdata : merge_q;
        state_d = dec_err ? RESP : (req_we && req_funct3 == 3'b010) ? WRITE : READ;
      end
      READ: begin
        REN = 1'b1;
        merge_d = we_q ? merged : merge_q;
        rdata_d = we_q ? rdata_q : ext;
        state_d = we_q ? WRITE : RESP;
      end
      WRITE: begin
        WEN = 1'b1;
        RW_type = 3'b010;
        state_d = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      we_q <= 1'b0;
      f3_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      merge_q <= '0;
      rdata_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q <= we_d;
      f3_q <= f3_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      merge_q <= merge_d;
      rdata_q <= rdata_d;
      err_q <= err_d;
    end
  end
endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed self-checking bench for lsu_ctrl against a small TCM model
module tb_lsu_ctrl;
  logic clk_en = 1'b1;
  logic CLK = 1'b0;
  logic RST_N, init;
  logic req_valid, req_we;
  logic req_ready, resp_valid, resp_err, REN, WEN;
  logic [2:0] req_funct3, RW_type;
  logic [5:0] req_addr;
  logic [31:0] req_wdata, resp_rdata, WDATA;
  logic [3:0] RADDR, WADDR;
  wire [31:0] RDATA;
  logic [31:0] mem [16];
  int n_cmp = 0, n_bad = 0;
  logic t_ren [1:4], t_wen [1:4], t_rv [1:4], t_err [1:4];
  logic [31:0] t_rdat [1:4], t_wdat [1:4];
  logic [3:0] t_raddr [1:4], t_waddr [1:4];
  logic [2:0] t_rwt [1:4];
  lsu_ctrl #(.AW(4), .DW(32)) dut (
    .CLK(CLK), .RST_N(RST_N), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .RADDR(RADDR), .REN(REN), .RDATA(RDATA),
    .WADDR(WADDR), .WDATA(WDATA), .WEN(WEN), .RW_type(RW_type)
  );
  always #5 CLK = ~CLK;
  assign RDATA = REN ? mem[RADDR] : 'z;
  always @(posedge CLK) begin
    if (init) for (int i = 0; i < 16; i++) mem[i] <= 32'h1000_0000 + 32'(i);
    else if (WEN === 1'b1) mem[WADDR] <= WDATA;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask
  task automatic req(input logic we, input logic [2:0] f3, input logic [5:0] a, input logic [31:0] wd);
    @(negedge CLK);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(posedge CLK); #1;
    req_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      if (k > 1) begin @(posedge CLK); #1; end
      t_ren[k] = REN; t_wen[k] = WEN; t_rv[k] = resp_valid; t_err[k] = resp_err;
      t_rdat[k] = resp_rdata; t_wdat[k] = WDATA; t_raddr[k] = RADDR; t_waddr[k] = WADDR; t_rwt[k] = RW_type;
    end
  endtask
  task automatic load(input string tag, input logic [2:0] f3, input logic [5:0] a, input logic [31:0] exp);
    req(1'b0, f3, a, 32'h0);
    chk({tag, " ren"}, {31'b0, t_ren[1]}, 1);
    chk({tag, " raddr"}, {28'b0, t_raddr[1]}, {28'b0, a[5:2]});
    chk({tag, " rv"}, {30'b0, t_rv[1], t_rv[2]}, 1);
    chk({tag, " rdata"}, t_rdat[2], exp);
    chk({tag, " err"}, {31'b0, t_err[2]}, 0);
  endtask
  task automatic bad(input string tag, input logic we, input logic [2:0] f3, input logic [5:0] a);
    req(we, f3, a, 32'hFFFF_FFFF);
    chk({tag, " rv"}, {31'b0, t_rv[1]}, 1);
    chk({tag, " err"}, {31'b0, t_err[1]}, 1);
    chk({tag, " rdata"}, t_rdat[1], 0);
    chk({tag, " ren/wen"}, {24'b0, t_ren[1], t_ren[2], t_ren[3], t_ren[4], t_wen[1], t_wen[2], t_wen[3], t_wen[4]}, 0);
  endtask
  initial begin
    RST_N = 1'b0; init = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b0; req_addr = 6'h0; req_wdata = 32'h0;
    #3;
    chk("rst ren/wen/rv", {29'b0, REN, WEN, resp_valid}, 0);
    chk("rst rw_type", {29'b0, RW_type}, 32'h7);
    chk("rst rdata", resp_rdata, 0);
    chk("rst err", {31'b0, resp_err}, 0);
    repeat (2) @(posedge CLK);
    @(negedge CLK); RST_N = 1'b1; init = 1'b0;
    #1 chk("rst ready", {31'b0, req_ready}, 1);
    req(1'b1, 3'b010, 6'h04, 32'hDEADBEEF);
    chk("sw wen", {31'b0, t_wen[1]}, 1);
    chk("sw ren", {31'b0, t_ren[1]}, 0);
    chk("sw waddr", {28'b0, t_waddr[1]}, 1);
    chk("sw rw_type", {29'b0, t_rwt[1]}, 32'h2);
    chk("sw wdata", t_wdat[1], 32'hDEADBEEF);
    chk("sw rv", {30'b0, t_rv[1], t_rv[2]}, 1);
    chk("sw err", {31'b0, t_err[2]}, 0);
    chk("sw rdata", t_rdat[2], 0);
    chk("sw rw_type idle", {29'b0, t_rwt[2]}, 32'h7);
    load("lb 07", 3'b000, 6'h07, 32'hFFFFFFDE);
    load("lbu 07", 3'b100, 6'h07, 32'h000000DE);
    load("lb 04", 3'b000, 6'h04, 32'hFFFFFFEF);
    load("lbu 05", 3'b100, 6'h05, 32'h000000BE);
    load("lh 04", 3'b001, 6'h04, 32'hFFFFBEEF);
    load("lhu 06", 3'b101, 6'h06, 32'h0000DEAD);
    load("lh 06", 3'b001, 6'h06, 32'hFFFFDEAD);
    load("lw 04", 3'b010, 6'h04, 32'hDEADBEEF);
    req(1'b1, 3'b000, 6'h05, 32'hFFFF_FF11);
    chk("sb read", {30'b0, t_ren[1], t_wen[1]}, 32'h2);
    chk("sb write", {30'b0, t_ren[2], t_wen[2]}, 32'h1);
    chk("sb wdata", t_wdat[2], 32'hDEAD11EF);
    chk("sb rv", {29'b0, t_rv[1], t_rv[2], t_rv[3]}, 1);
    load("lw after sb", 3'b010, 6'h04, 32'hDEAD11EF);
    req(1'b1, 3'b001, 6'h06, 32'hABCD_1234);
    chk("sh wdata", t_wdat[2], 32'h123411EF);
    chk("sh rv", {29'b0, t_rv[1], t_rv[2], t_rv[3]}, 1);
    load("lw after sh", 3'b010, 6'h04, 32'h123411EF);
    bad("lw 02", 1'b0, 3'b010, 6'h02);
    bad("sh 03", 1'b1, 3'b001, 6'h03);
    bad("sb f3=100", 1'b1, 3'b100, 6'h08);
    bad("ld f3=011", 1'b0, 3'b011, 6'h00);
    load("lw 00 intact", 3'b010, 6'h00, 32'h10000000);
    load("lw 08 intact", 3'b010, 6'h08, 32'h10000002);
    @(negedge CLK);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 6'h04;
    @(posedge CLK); #1;
    chk("b2b ready T+1", {31'b0, req_ready}, 0);
    req_addr = 6'h08;
    @(posedge CLK); #1;
    chk("b2b ready T+2", {31'b0, req_ready}, 0);
    chk("b2b rv1", {31'b0, resp_valid}, 1);
    chk("b2b rdata1", resp_rdata, 32'h123411EF);
    @(posedge CLK); #1;
    chk("b2b ready T+3", {30'b0, req_ready, resp_valid}, 32'h2);
    @(posedge CLK); #1;
    req_valid = 1'b0;
    chk("b2b ren2", {31'b0, REN}, 1);
    chk("b2b raddr2", {28'b0, RADDR}, 2);
    @(posedge CLK); #1;
    chk("b2b rv2", {31'b0, resp_valid}, 1);
    chk("b2b rdata2", resp_rdata, 32'h10000002);
    @(posedge CLK); #1;
    chk("b2b idle", {29'b0, req_ready, resp_valid, REN}, 32'h4);
    @(posedge CLK); #1;
    chk("b2b no dup", {30'b0, resp_valid, REN}, 0);
    @(negedge CLK);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 6'h08; req_wdata = 32'hCAFEF00D;
    @(posedge CLK); #1;
    req_valid = 1'b0;
    chk("abort wen", {31'b0, WEN}, 1);
    #2 RST_N = 1'b0;
    #1;
    chk("abort wen drop", {30'b0, WEN, REN}, 0);
    chk("abort rw_type", {29'b0, RW_type}, 32'h7);
    chk("abort rv/err", {30'b0, resp_valid, resp_err}, 0);
    chk("abort rdata", resp_rdata, 0);
    chk("abort wdata", WDATA, 0);
    @(posedge CLK); #1;
    chk("abort no rv", {31'b0, resp_valid}, 0);
    @(negedge CLK); RST_N = 1'b1;
    #1 chk("abort ready", {31'b0, req_ready}, 1);
    load("lw 08 old", 3'b010, 6'h08, 32'h10000002);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
